// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the round-robin UART byte scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_sched_pkg;

    localparam int         ID_W            = 3;
    localparam logic [7:0] HEADER_BASE_DEF = 8'hA0;

    // Index of the final byte of a frame: header+LSB+MSB, or LSB+MSB.
    localparam logic [1:0] LAST_IDX_HDR = 2'd2;
    localparam logic [1:0] LAST_IDX_RAW = 2'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_DONE
    } state_t;

    function automatic logic [1:0] last_idx(input bit hdr_en);
        return hdr_en ? LAST_IDX_HDR : LAST_IDX_RAW;
    endfunction

endpackage

// File: rtl/uart_tx_sched_arb.sv
// Round-robin arbiter: first requester at or after ptr (mod NREQ) wins.
// Latency: winner/valid are combinational from req and the ptr register.
// Backpressure: ptr only moves on an advance strobe from the owner.
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    input  logic [ID_W-1:0] next_ptr,
    output logic [ID_W-1:0] winner,
    output logic            valid
);

    logic [ID_W-1:0] ptr;
    logic [NREQ-1:0] rot;
    logic [ID_W:0]   sum;

    // Priority pointer: moves only when the owner finishes a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= next_ptr;
        end
    end

    // Rotate requests so bit 0 is the ptr position; lowest set bit wins.
    always_comb begin
        rot    = NREQ'({req, req} >> ptr);
        winner = '0;
        valid  = 1'b0;
        sum    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + (ID_W + 1)'(k);
                if (sum >= (ID_W + 1)'(NREQ)) begin
                    sum = sum - (ID_W + 1)'(NREQ);
                end
                winner = sum[ID_W-1:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one byte UART transmitter among NREQ word requesters, round-robin.
// Latency: ack and first start 1 cycle after the sampling edge; 2 idle cycles between frames.
// Backpressure: waits for xmit_done high before each frame and between bytes.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int         NREQ        = 4,
    parameter bit         HEADER_EN   = 1'b1,
    parameter logic [7:0] HEADER_BASE = HEADER_BASE_DEF
) (
    input  logic               sys_clk,
    input  logic               sys_rst_l,
    input  logic [NREQ-1:0]    req,
    input  logic [16*NREQ-1:0] req_data,
    output logic [NREQ-1:0]    req_ack,
    output logic [NREQ-1:0]    req_done,
    output logic               xmit_start,
    output logic [7:0]         xmit_data,
    input  logic               xmit_done,
    output logic               busy,
    output logic [ID_W-1:0]    cur_id
);

    localparam logic [1:0] LAST = last_idx(HEADER_EN);

    state_t          state;
    logic [15:0]     word_q;
    logic [1:0]      byte_idx;
    logic [ID_W-1:0] winner;
    logic            win_vld;
    logic [ID_W-1:0] next_ptr;
    logic [15:0]     win_word;
    logic            adv;

    // Pointer advances past the owner once its frame has completed.
    assign adv      = (state == ST_DONE);
    assign next_ptr = (cur_id == ID_W'(NREQ - 1)) ? '0 : cur_id + 1'b1;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk      (sys_clk),
        .rst_n    (sys_rst_l),
        .req      (req),
        .adv      (adv),
        .next_ptr (next_ptr),
        .winner   (winner),
        .valid    (win_vld)
    );

    // Select the winning requester's word with constant slices only.
    always_comb begin
        win_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_word = req_data[16*i +: 16];
            end
        end
    end

    // Frame sequencer with all outputs registered.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state      <= ST_IDLE;
            word_q     <= '0;
            byte_idx   <= '0;
            req_ack    <= '0;
            req_done   <= '0;
            xmit_start <= 1'b0;
            xmit_data  <= '0;
            busy       <= 1'b0;
            cur_id     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_done <= '0;
                    if (win_vld && xmit_done) begin
                        word_q     <= win_word;
                        cur_id     <= winner;
                        byte_idx   <= '0;
                        xmit_data  <= HEADER_EN ? (HEADER_BASE | {5'b0, winner}) : win_word[7:0];
                        xmit_start <= 1'b1;
                        req_ack    <= NREQ'(1'b1) << winner;
                        busy       <= 1'b1;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    xmit_start <= 1'b0;
                    req_ack    <= '0;
                    state      <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!xmit_done) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (xmit_done) begin
                        if (byte_idx == LAST) begin
                            req_done <= NREQ'(1'b1) << cur_id;
                            state    <= ST_DONE;
                        end else begin
                            // The byte just before the last is always the LSB.
                            byte_idx   <= byte_idx + 2'd1;
                            xmit_data  <= (byte_idx + 2'd1 == LAST) ? word_q[15:8] : word_q[7:0];
                            xmit_start <= 1'b1;
                            state      <= ST_SEND;
                        end
                    end
                end
                ST_DONE: begin
                    req_done <= '0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed and randomized checks of uart_tx_sched against a frame-level model.
// Latency: n/a.
// Backpressure: transmitter model holds done low for a fixed number of cycles per byte.
module tb_uart_tx_sched;

    localparam int DLY = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic [3:0]  req_a, ack_a, done_a;
    logic [63:0] data_a;
    logic        xs_a, xdone_a, busy_a;
    logic [7:0]  xd_a;
    logic [2:0]  cid_a;

    logic [3:0]  req_b, ack_b, done_b;
    logic [63:0] data_b;
    logic        xs_b, xdone_b, busy_b;
    logic [7:0]  xd_b;
    logic [2:0]  cid_b;

    int checks = 0;
    int failures = 0;

    int         acks_a[$], dones_a[$], acks_b[$], dones_b[$];
    logic [7:0] bytes_a[$], bytes_b[$];
    int         exp_ids[$];
    logic [7:0] exp_bytes[$];

    int cnt_a, cnt_b;
    bit force_low_a;
    bit auto_drop;
    int ptr_m;

    always #5 clk = ~clk;

    uart_tx_sched #(.NREQ(4), .HEADER_EN(1'b1), .HEADER_BASE(8'hA0)) dut_a (
        .sys_clk    (clk),
        .sys_rst_l  (rst_n),
        .req        (req_a),
        .req_data   (data_a),
        .req_ack    (ack_a),
        .req_done   (done_a),
        .xmit_start (xs_a),
        .xmit_data  (xd_a),
        .xmit_done  (xdone_a),
        .busy       (busy_a),
        .cur_id     (cid_a)
    );

    uart_tx_sched #(.NREQ(4), .HEADER_EN(1'b0), .HEADER_BASE(8'hA0)) dut_b (
        .sys_clk    (clk),
        .sys_rst_l  (rst_n),
        .req        (req_b),
        .req_data   (data_b),
        .req_ack    (ack_b),
        .req_done   (done_b),
        .xmit_start (xs_b),
        .xmit_data  (xd_b),
        .xmit_done  (xdone_b),
        .busy       (busy_b),
        .cur_id     (cid_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample outputs at the falling edge, then drive the requester and transmitter models.
    task automatic tick();
        @(negedge clk);
        if (xs_a) bytes_a.push_back(xd_a);
        if (xs_b) bytes_b.push_back(xd_b);
        for (int i = 0; i < 4; i++) begin
            if (ack_a[i]) begin
                acks_a.push_back(i);
                if (auto_drop) req_a[i] = 1'b0;
            end
            if (done_a[i]) dones_a.push_back(i);
            if (ack_b[i]) begin
                acks_b.push_back(i);
                req_b[i] = 1'b0;
            end
            if (done_b[i]) dones_b.push_back(i);
        end
        if (force_low_a) begin
            xdone_a = 1'b0;
        end else if (xs_a) begin
            xdone_a = 1'b0;
            cnt_a   = DLY;
        end else if (cnt_a > 0) begin
            cnt_a--;
            if (cnt_a == 0) xdone_a = 1'b1;
        end
        if (xs_b) begin
            xdone_b = 1'b0;
            cnt_b   = DLY;
        end else if (cnt_b > 0) begin
            cnt_b--;
            if (cnt_b == 0) xdone_b = 1'b1;
        end
    endtask

    task automatic run_frames(input int which, input int n);
        int budget = 3000;
        while (((which == 0) ? dones_a.size() : dones_b.size()) < n && budget > 0) begin
            tick();
            budget--;
        end
        check("frame_timeout", (((which == 0) ? dones_a.size() : dones_b.size()) >= n), 1);
    endtask

    function automatic int next_grant(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic expect_frame(input int id, input logic [15:0] w, input bit hdr);
        exp_ids.push_back(id);
        if (hdr) exp_bytes.push_back(8'hA0 | 8'(id));
        exp_bytes.push_back(w[7:0]);
        exp_bytes.push_back(w[15:8]);
    endtask

    task automatic clear_logs();
        acks_a.delete(); dones_a.delete(); bytes_a.delete();
        acks_b.delete(); dones_b.delete(); bytes_b.delete();
        exp_ids.delete(); exp_bytes.delete();
    endtask

    task automatic compare(input int which, input string tag);
        int         ac[$];
        int         dn[$];
        logic [7:0] by[$];
        if (which == 0) begin
            ac = acks_a; dn = dones_a; by = bytes_a;
        end else begin
            ac = acks_b; dn = dones_b; by = bytes_b;
        end
        check({tag, "_nack"},  ac.size(), exp_ids.size());
        check({tag, "_ndone"}, dn.size(), exp_ids.size());
        check({tag, "_nbyte"}, by.size(), exp_bytes.size());
        foreach (exp_ids[i]) begin
            check({tag, "_ack_id"},  (i < ac.size()) ? ac[i] : -1, exp_ids[i]);
            check({tag, "_done_id"}, (i < dn.size()) ? dn[i] : -1, exp_ids[i]);
        end
        foreach (exp_bytes[i]) begin
            check({tag, "_byte"}, (i < by.size()) ? {24'h0, by[i]} : 32'hDEAD, {24'h0, exp_bytes[i]});
        end
        clear_logs();
    endtask

    task automatic reset_models();
        xdone_a = 1'b1; cnt_a = 0; force_low_a = 1'b0;
        xdone_b = 1'b1; cnt_b = 0;
    endtask

    initial begin
        logic [3:0]  mask;
        logic [15:0] w;
        int          last;
        int          nf;

        req_a = '0; data_a = '0; req_b = '0; data_b = '0;
        auto_drop = 1'b1;
        ptr_m = 0;
        reset_models();

        // Reset state, observed before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst_ack",   ack_a, 0);
        check("rst_done",  done_a, 0);
        check("rst_start", xs_a, 0);
        check("rst_data",  xd_a, 0);
        check("rst_busy",  busy_a, 0);
        check("rst_cur_id", cid_a, 0);
        check("rst_start_b", xs_b, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Single frame from requester 2; ack and start one cycle after the sampling edge.
        data_a[47:32] = 16'h1234;
        req_a = 4'b0100;
        tick();
        check("t1_ack_latency",   acks_a.size(), 1);
        check("t1_start_latency", bytes_a.size(), 1);
        check("t1_busy_on",       busy_a, 1);
        check("t1_cur_id",        cid_a, 2);
        run_frames(0, 1);
        check("t1_busy_in_done", busy_a, 1);
        tick();
        check("t1_busy_drop", busy_a, 0);
        check("t1_done_pulse", done_a, 0);
        check("t1_cur_id_hold", cid_a, 2);
        tick();
        expect_frame(2, 16'h1234, 1'b1);
        compare(0, "t1");

        // Held requests 1011 from reset: rotation 0,1,3,...
        rst_n = 1'b0;
        reset_models();
        tick();
        rst_n = 1'b1;
        ptr_m = 0;
        auto_drop = 1'b0;
        for (int i = 0; i < 4; i++) data_a[16*i +: 16] = 16'(16'h1100 * i);
        for (int f = 0; f < 6; f++) begin
            last = next_grant(4'b1011, ptr_m);
            expect_frame(last, 16'(16'h1100 * last), 1'b1);
            ptr_m = (last + 1) % 4;
        end
        req_a = 4'b1011;
        run_frames(0, 6);
        req_a = '0;
        auto_drop = 1'b1;
        repeat (3) tick();
        for (int i = 1; i < dones_a.size(); i++) begin
            check("t2_no_repeat", (dones_a[i] != dones_a[i-1]), 1);
        end
        compare(0, "t2");

        // Headerless instance: two bytes only.
        data_b[31:16] = 16'hBEEF;
        req_b = 4'b0010;
        run_frames(1, 1);
        repeat (2) tick();
        expect_frame(1, 16'hBEEF, 1'b0);
        compare(1, "t3");

        // Data changed after ack must not affect the frame in flight.
        data_a[15:0] = 16'h0055;
        req_a = 4'b0001;
        tick();
        check("t4_ack", acks_a.size(), 1);
        tick();
        data_a[15:0] = 16'hFFFF;
        run_frames(0, 1);
        repeat (2) tick();
        expect_frame(0, 16'h0055, 1'b1);
        compare(0, "t4");
        ptr_m = 1;

        // Transmitter not ready at idle: nothing starts until done returns.
        force_low_a = 1'b1;
        xdone_a = 1'b0;
        data_a[63:48] = 16'hC3C3;
        req_a = 4'b1000;
        repeat (6) tick();
        check("t5_no_ack",   acks_a.size(), 0);
        check("t5_no_start", bytes_a.size(), 0);
        check("t5_idle",     busy_a, 0);
        force_low_a = 1'b0;
        xdone_a = 1'b1;
        tick();
        check("t5_ack_after_release",   acks_a.size(), 1);
        check("t5_start_after_release", bytes_a.size(), 1);
        run_frames(0, 1);
        repeat (2) tick();
        expect_frame(3, 16'hC3C3, 1'b1);
        compare(0, "t5");
        ptr_m = 0;

        // Reset during the second byte of a frame; pointer returns to 0.
        auto_drop = 1'b0;
        data_a[31:16] = 16'h5A11;
        data_a[47:32] = 16'h5A22;
        req_a = 4'b0110;
        run_frames(0, 1);
        check("t6_first_owner", (dones_a.size() > 0) ? dones_a[0] : -1, 1);
        nf = 3000;
        while (bytes_a.size() < 5 && nf > 0) begin
            tick();
            nf--;
        end
        check("t6_reach_byte2", (bytes_a.size() >= 5), 1);
        repeat (3) tick();
        check("t6_busy_before_rst", busy_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_start", xs_a, 0);
        check("t6_rst_busy",  busy_a, 0);
        check("t6_rst_ack",   ack_a, 0);
        check("t6_rst_done",  done_a, 0);
        clear_logs();
        reset_models();
        tick();
        check("t6_no_done_abort", dones_a.size(), 0);
        rst_n = 1'b1;
        run_frames(0, 1);
        req_a = '0;
        auto_drop = 1'b1;
        repeat (3) tick();
        expect_frame(1, 16'h5A11, 1'b1);
        compare(0, "t6");
        ptr_m = 2;

        // Randomized rounds: simultaneous requests served once each in rotation order.
        for (int r = 0; r < 6; r++) begin
            mask = 4'($urandom_range(1, 15));
            nf = 0;
            last = ptr_m;
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) data_a[16*i +: 16] = 16'($urandom);
            end
            for (int k = 0; k < 4; k++) begin
                if (mask[(ptr_m + k) % 4]) begin
                    last = (ptr_m + k) % 4;
                    w = data_a[16*last +: 16];
                    expect_frame(last, w, 1'b1);
                    nf++;
                end
            end
            ptr_m = (last + 1) % 4;
            req_a = mask;
            run_frames(0, nf);
            repeat (2) tick();
            compare(0, "t7");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one byte-wide UART transmitter (u_xmit-style start/data/done interface) among NREQ requesters, each offering a 16-bit word.
For each granted word it sends an optional header byte (HEADER_BASE | requester id), then the LSB, then the MSB.
It then signals completion back to the owning requester.
It runs on the baud clock domain, between the client logic and the transmitter.

Parameters:
NREQ, 4, number of requesters, legal 2..8
HEADER_EN, 1, 1 = prefix a header byte to each frame; 0 = two data bytes only
HEADER_BASE, 8'hA0, header byte = HEADER_BASE | {5'b0, id}; low 3 bits of HEADER_BASE must be 0

Ports:
sys_clk  in  1  single clock (baud clock domain)
sys_rst_l  in  1  reset, asynchronous, active-low
req  in  NREQ  level request per requester; held until req_ack
req_data  in  16*NREQ  word of requester i on bits [16i+15:16i]
req_ack  out  NREQ  one-hot, 1-cycle pulse: word captured; requester may change data or drop req
req_done  out  NREQ  one-hot, 1-cycle pulse: all bytes of that requester's frame transmitted
xmit_start  out  1  1-cycle pulse to transmitter: send xmit_data
xmit_data  out  8  byte to transmit, stable from the start pulse until done returns high
xmit_done  in  1  transmitter level: 1 = idle or finished, 0 = shifting
busy  out  1  1 while a frame is in progress (any state other than IDLE)
cur_id  out  3  id of the current frame owner; holds last value when idle

Behaviour:
- Reset (async, sys_rst_l=0): state=IDLE; ptr=0; byte_idx=0. All outputs 0: req_ack, req_done, xmit_start, xmit_data, busy, cur_id.
- Reset mid-frame aborts at once: xmit_start drops without waiting for a clock, and no req_done is issued for the aborted frame.
- Arbitration: winner = first i in ptr, ptr+1, ... ptr+NREQ-1 (mod NREQ) with req[i]=1.
- ptr updates only in DONE, to (cur_id+1) mod NREQ. A requester that holds req continuously is served again only after every other pending requester.
- States and transitions:
  - IDLE: if |req and xmit_done=1, then on the clock edge capture req_data[winner] into word_q, set cur_id=winner, load xmit_data (header if HEADER_EN, else word_q[7:0]), byte_idx=0, go to SEND. req_ack[winner]=1 during the SEND cycle. If xmit_done=0, stay in IDLE even when req is pending.
  - SEND: xmit_start=1 for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: stay until xmit_done=0, then go to WAIT_DONE. The transmitter is required to drop done within 2 cycles of start.
  - WAIT_DONE: stay until xmit_done=1.
    - If byte_idx = last (2 with header, 1 without), go to DONE.
    - Otherwise byte_idx+1, load the next byte (word_q[7:0], then word_q[15:8]), go to SEND.
  - DONE: req_done[cur_id]=1 for one cycle, ptr update, go to IDLE.
- Latency: a request arriving at an idle scheduler produces req_ack and xmit_start 1 cycle after the sampling edge. Back-to-back frames have 2 cycles minimum from the last done rising to the next start (DONE, IDLE).
- A new req asserted during a frame waits. req_data changes after req_ack have no effect on the frame in flight.
- req deasserted before ack: that requester is not granted. There is no partial state.
- busy = (state != IDLE). xmit_data changes only on entry to SEND.
- All outputs are registered or decoded from state only, with no combinational path from req or xmit_done.

Decomposition:
- Package uart_sched_pkg: state encoding (IDLE, SEND, WAIT_BUSY, WAIT_DONE, DONE), ID_W=3, the HEADER_BASE default, and the byte-count constants.
- Sub-module rr_arbiter(NREQ): owns the ptr register and produces winner and a valid flag; it takes an advance strobe plus next_ptr. The top level holds the FSM, word_q, byte_idx and the output registers.

Test Plan:
1. NREQ=4, HEADER_EN=1, req[2] with data 16'h1234, transmitter model with done low for 10 cycles per byte -> xmit_data sequence 8'hA2, 8'h34, 8'h12; three start pulses; req_ack[2] once; req_done[2] once after the third done rise; busy drops the next cycle.
2. req=4'b1011 held continuously, each word = 16'h1100*i, from reset -> grant order 0, 1, 3, 0, 1, 3. Each frame carries the correct id header. No requester is served twice in a row while others are pending.
3. HEADER_EN=0, req[1] with data 16'hBEEF -> exactly two bytes, 8'hEF then 8'hBE; req_done[1] after the second done rise.
4. req_data[0] changed to 16'hFFFF one cycle after req_ack[0] (original 16'h0055) -> bytes 8'hA0, 8'h55, 8'h00 are sent unchanged.
5. xmit_done held 0 at idle with req[3]=1 -> no ack or start. Release done -> ack and start one cycle later.
6. sys_rst_l pulsed low during WAIT_DONE of the second byte -> xmit_start, busy, req_ack and req_done are 0 immediately. No req_done for the aborted frame. After release, the pending request is re-arbitrated from ptr=0 and its full frame restarts.
